fmac_sched: RTL and testbench
=============================

# fmac_sched

Job-level scheduler that time-shares one 8x8 multiply-accumulate datapath between NREQ requesters. A requester submits a job (vector length, threshold). The scheduler grants one job at a time in round-robin order and streams that requester's operand pairs through the MAC step at one pair per cycle. It applies the threshold/overflow clamp rule and returns the final accumulator on a result handshake. It sits between the operand-producing front ends and downstream consumers of accumulated results.

## Interface
- NREQ, 2, number of requesters (2..8)
- LEN_W, 8, width of job length and clamp counter
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- req  in  NREQ  job request per requester; job fields sampled on grant
- job_len  in  NREQ*LEN_W  element count per requester, slice i = requester i
- job_thr  in  NREQ*16  unsigned threshold per requester
- gnt  out  NREQ  one-hot, high for whole job (RUN through result handshake)
- op_valid  in  NREQ  operand pair valid
- op_x, op_y  in  NREQ*8 each  unsigned operands
- op_ready  out  NREQ  one-hot, high only for granted requester in RUN
- res_valid  out  1  result available
- res_data  out  16  final accumulator
- res_id  out  3  index of requester owning result
- res_clamps  out  LEN_W  number of clamp events in job
- res_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if any req bit is high, select the first set bit at or after rr_ptr (wrapping). Latch id, len, thr. Clear acc and cnt, and clear clamps. Go to RUN, or go to DONE if len==0.
- RUN: op_ready[id]=1. On op_valid[id]&&op_ready[id]: prod=x*y (16b), sum=acc+prod (17b).
  - Clamp when sum[16]==1 or sum[15:0]<thr: acc<=0, clamps++ (saturates at all-ones).
  - Otherwise acc<=sum[15:0].
  - cnt++.
  - The handshake with cnt==len-1 moves the block to DONE.
- DONE: res_valid=1, res_data=acc, res_id=id, res_clamps=clamps. Outputs stay stable until res_ready. On handshake: rr_ptr<=id+1 (mod NREQ), gnt<=0, go to IDLE.
- Req deasserted after grant is ignored; the job runs to completion. Req deasserted before grant removes the request.
- op_valid/op_x/op_y of non-granted requesters are ignored.
- Reset (any state, asynchronous): state=IDLE, gnt=0, op_ready=0, res_valid=0, res_data=0, res_id=0, res_clamps=0, acc=0, cnt=0, rr_ptr=0, busy=0. An in-flight job is discarded.

## Timing
- Grant latency: req seen in IDLE at edge T sets gnt and op_ready at T+1.
- Throughput: one operand pair per cycle in RUN. No bubbles while op_valid is held.
- Result latency: last operand handshake at edge T sets res_valid at T+1.
- len==0: DONE at grant edge T+1 with res_data=0 and clamps=0. op_ready is never asserted.
- After result handshake at edge T: IDLE at T+1. Next grant earliest at T+2.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- FMAC_SCHED_CLAMP_CNT_EN defined: clamp counter implemented and res_clamps driven as described.
- FMAC_SCHED_CLAMP_CNT_EN undefined: counter removed. res_clamps tied to 0. All other behaviour identical.

## Structure
- Shared package/header fmac_defs: state encodings (IDLE/RUN/DONE), DATA_W=8, ACC_W=16.
- Sub-module fmac_step: combinational multiply, 17-bit add, threshold/overflow clamp. Inputs: acc, x, y, thr. Outputs: next_acc, clamp. One instance in fmac_sched.
- Round-robin pick, counters and FSM stay in fmac_sched.

## Test plan
- Basic job: req0, len=3, thr=0, pairs (2,3),(4,5),(1,1) -> res_data=27, res_id=0, res_clamps=0; res_valid the cycle after the 3rd handshake.
- Threshold clamp: req0, len=2, thr=100, pairs (5,5),(10,12) -> 25<100 clamps to 0, then 120 -> res_data=120, res_clamps=1.
- Overflow clamp: len=2, thr=0, pairs (255,255),(255,255) -> 65025, then 130050 overflows -> res_data=0, res_clamps=1.
- Round-robin: after reset, req0 and req1 held high with len=1 -> grants in order 0, 1, 0, 1. Each result res_id matches its grant.
- Backpressure and len=0: req1 len=0 -> DONE one cycle after grant, res_data=0. Hold res_ready low 5 cycles -> outputs stable, no new gnt, busy=1.
- Reset mid-RUN: drop RESET after 2 of 4 operands -> all outputs 0 immediately. After release, a fresh job gets grant with rr_ptr=0 and the correct result.

Source files
------------

// File: rtl/fmac_sched_pkg.sv
// Shared definitions for the fmac_sched job scheduler.
//   DATA_W : operand width of one MAC input
//   ACC_W  : accumulator / threshold / result width
//   ID_W   : width of a requester index (up to 8 requesters)
//   state_e: scheduler states IDLE / RUN / DONE
package fmac_sched_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int ID_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fmac_sched_step.sv
// fmac_step: one combinational multiply-accumulate step with clamp rule.
// Ports:
//   acc_i      current accumulator
//   x_i, y_i   unsigned operand pair
//   thr_i      unsigned threshold
//   next_acc_o accumulator after this step (0 when clamped)
//   clamp_o    high when the 17-bit sum overflowed or fell below threshold
module fmac_step
    import fmac_sched_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [ACC_W-1:0]  thr_i,
    output logic [ACC_W-1:0]  next_acc_o,
    output logic              clamp_o
);

    logic [ACC_W-1:0] prod;
    logic [ACC_W:0]   sum;

    assign prod = ACC_W'(x_i) * ACC_W'(y_i);
    assign sum  = {1'b0, acc_i} + {1'b0, prod};

    // Bit ACC_W of the sum is the overflow out of the 16-bit accumulator.
    assign clamp_o    = sum[ACC_W] | (sum[ACC_W-1:0] < thr_i);
    assign next_acc_o = clamp_o ? '0 : sum[ACC_W-1:0];

endmodule

// File: rtl/fmac_sched.sv
// fmac_sched: round-robin job scheduler sharing one 8x8 MAC step between
// NREQ requesters. A granted job streams len operand pairs through the MAC,
// then presents the final accumulator on a valid/ready result port.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i              job request per requester
//   job_len_i          per-requester element count (slice i = requester i)
//   job_thr_i          per-requester 16-bit unsigned threshold
//   gnt_o              one-hot grant, held for the whole job
//   op_valid_i         per-requester operand valid
//   op_x_i, op_y_i     per-requester 8-bit operands
//   op_ready_o         one-hot operand ready, granted requester in RUN only
//   res_valid_o        result available
//   res_data_o         final accumulator
//   res_id_o           requester owning the result
//   res_clamps_o       clamp events during the job
//   res_ready_i        consumer accepts result
//   busy_o             scheduler not idle
// Configuration macro FMAC_SCHED_CLAMP_CNT_EN: when defined the clamp event
// counter is built and drives res_clamps_o; otherwise res_clamps_o is 0.
module fmac_sched
    import fmac_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LEN_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*LEN_W-1:0]   job_len_i,
    input  logic [NREQ*ACC_W-1:0]   job_thr_i,
    output logic [NREQ-1:0]         gnt_o,
    input  logic [NREQ-1:0]         op_valid_i,
    input  logic [NREQ*DATA_W-1:0]  op_x_i,
    input  logic [NREQ*DATA_W-1:0]  op_y_i,
    output logic [NREQ-1:0]         op_ready_o,
    output logic                    res_valid_o,
    output logic [ACC_W-1:0]        res_data_o,
    output logic [ID_W-1:0]         res_id_o,
    output logic [LEN_W-1:0]        res_clamps_o,
    input  logic                    res_ready_i,
    output logic                    busy_o
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   thr_q, thr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    rdy_q, rdy_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;

    logic               sel_vld;
    logic [DATA_W-1:0]  sel_x, sel_y;
    logic               pick_vld;
    logic [ID_W-1:0]    pick_id;
    logic [LEN_W-1:0]   pick_len;
    logic [ACC_W-1:0]   pick_thr;
    logic [ACC_W-1:0]   step_acc;
    logic               step_clamp;

`ifdef FMAC_SCHED_CLAMP_CNT_EN
    logic [LEN_W-1:0]   clamps_q, clamps_d;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction
`else
    logic               unused_clamp;
    assign unused_clamp = step_clamp;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (idx == ID_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Operand mux for the granted requester.
    always_comb begin
        sel_vld = 1'b0;
        sel_x   = '0;
        sel_y   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (id_q == ID_W'(i)) begin
                sel_vld = op_valid_i[i];
                sel_x   = op_x_i[i*DATA_W +: DATA_W];
                sel_y   = op_y_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin pick: scan slots rr_q, rr_q+1, ... (wrapping), first
    // requesting slot wins.
    always_comb begin
        int slot;
        slot     = 0;
        pick_vld = 1'b0;
        pick_id  = '0;
        pick_len = '0;
        pick_thr = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot = int'(rr_q) + k;
            if (slot >= NREQ) slot = slot - NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!pick_vld && slot == j && req_i[j]) begin
                    pick_vld = 1'b1;
                    pick_id  = ID_W'(j);
                    pick_len = job_len_i[j*LEN_W +: LEN_W];
                    pick_thr = job_thr_i[j*ACC_W +: ACC_W];
                end
            end
        end
    end

    fmac_step u_step (
        .acc_i      (acc_q),
        .x_i        (sel_x),
        .y_i        (sel_y),
        .thr_i      (thr_q),
        .next_acc_o (step_acc),
        .clamp_o    (step_clamp)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        acc_d   = acc_q;
        gnt_d   = gnt_q;
        rdy_d   = rdy_q;
`ifdef FMAC_SCHED_CLAMP_CNT_EN
        clamps_d = clamps_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    id_d  = pick_id;
                    len_d = pick_len;
                    thr_d = pick_thr;
                    acc_d = '0;
                    cnt_d = '0;
`ifdef FMAC_SCHED_CLAMP_CNT_EN
                    clamps_d = '0;
`endif
                    gnt_d = onehot(pick_id);
                    // Empty jobs skip RUN so op_ready is never raised.
                    if (pick_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        rdy_d   = onehot(pick_id);
                    end
                end
            end
            ST_RUN: begin
                if (sel_vld) begin
                    acc_d = step_acc;
`ifdef FMAC_SCHED_CLAMP_CNT_EN
                    if (step_clamp) clamps_d = sat_inc(clamps_q);
`endif
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = ST_DONE;
                        rdy_d   = '0;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready_i) begin
                    rr_d    = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                rdy_d   = '0;
            end
        endcase
        // Status outputs are registered copies of the next state.
        vld_d  = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            rr_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= '0;
            acc_q   <= '0;
            gnt_q   <= '0;
            rdy_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef FMAC_SCHED_CLAMP_CNT_EN
            clamps_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            acc_q   <= acc_d;
            gnt_q   <= gnt_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
`ifdef FMAC_SCHED_CLAMP_CNT_EN
            clamps_q <= clamps_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign op_ready_o  = rdy_q;
    assign res_valid_o = vld_q;
    assign res_data_o  = acc_q;
    assign res_id_o    = id_q;
    assign busy_o      = busy_q;
`ifdef FMAC_SCHED_CLAMP_CNT_EN
    assign res_clamps_o = clamps_q;
`else
    assign res_clamps_o = '0;
`endif

endmodule

// File: tb/tb_fmac_sched.sv
// Self-checking bench for fmac_sched (NREQ=2, LEN_W=8): directed jobs with
// literal expected results, then randomized traffic against a job-level
// reference model that is compared with the DUT every cycle.
module tb_fmac_sched;

    localparam int NREQ  = 2;
    localparam int LEN_W = 8;
`ifdef FMAC_SCHED_CLAMP_CNT_EN
    localparam int CL1 = 1;
`else
    localparam int CL1 = 0;
`endif

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*8-1:0]  job_len;
    logic [NREQ*16-1:0] job_thr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    op_valid;
    logic [NREQ*8-1:0]  op_x;
    logic [NREQ*8-1:0]  op_y;
    logic [NREQ-1:0]    op_ready;
    logic               res_valid;
    logic [15:0]        res_data;
    logic [2:0]         res_id;
    logic [7:0]         res_clamps;
    logic               res_ready;
    logic               busy;

    fmac_sched #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .job_len_i    (job_len),
        .job_thr_i    (job_thr),
        .gnt_o        (gnt),
        .op_valid_i   (op_valid),
        .op_x_i       (op_x),
        .op_y_i       (op_y),
        .op_ready_o   (op_ready),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_id_o     (res_id),
        .res_clamps_o (res_clamps),
        .res_ready_i  (res_ready),
        .busy_o       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Operand pairs waiting per requester, {x,y}.
    logic [15:0] pq0[$];
    logic [15:0] pq1[$];
    bit          gap_mode = 0;
    int          hs_cnt1  = 0;

    // Result logs: DUT side and model side.
    int d_data[$], d_id[$], d_cl[$];
    int m_data[$], m_idl[$], m_cl[$];

    // ---------------- reference model (job level, plain integers) ----------
    int m_ph = 0;      // 0 idle, 1 streaming operands, 2 result pending
    int m_id = 0, m_len = 0, m_thr = 0, m_acc = 0, m_cnt = 0, m_clamps = 0, m_rr = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = 0; m_id = 0; m_len = 0; m_thr = 0;
                m_acc = 0; m_cnt = 0; m_clamps = 0; m_rr = 0;
            end else begin
                case (m_ph)
                    0: begin : pick
                        bit found;
                        found = 0;
                        for (int k = 0; k < NREQ; k++) begin
                            int j;
                            j = (m_rr + k) % NREQ;
                            if (!found && ((req >> j) & 1) == 1) begin
                                found = 1;
                                m_id  = j;
                            end
                        end
                        if (found) begin
                            m_len    = int'((job_len >> (8 * m_id)) & 16'h00FF);
                            m_thr    = int'((job_thr >> (16 * m_id)) & 32'h0000FFFF);
                            m_acc    = 0;
                            m_cnt    = 0;
                            m_clamps = 0;
                            m_ph     = (m_len == 0) ? 2 : 1;
                        end
                    end
                    1: begin
                        if (((op_valid >> m_id) & 1) == 1) begin : mac
                            int x, y, s;
                            x = int'((op_x >> (8 * m_id)) & 16'h00FF);
                            y = int'((op_y >> (8 * m_id)) & 16'h00FF);
                            s = m_acc + x * y;
                            if (s > 65535 || s < m_thr) begin
                                m_acc = 0;
                                if (m_clamps < 255) m_clamps++;
                            end else begin
                                m_acc = s;
                            end
                            m_cnt++;
                            if (m_cnt == m_len) m_ph = 2;
                        end
                    end
                    default: begin
                        if (res_ready) begin
                            m_data.push_back(m_acc);
                            m_idl.push_back(m_id);
                            m_cl.push_back(m_clamps);
                            m_rr = (m_id + 1) % NREQ;
                            m_ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            int e_gnt, e_rdy, e_cl;
            @(negedge clk);
            e_gnt = (m_ph != 0) ? (1 << m_id) : 0;
            e_rdy = (m_ph == 1) ? (1 << m_id) : 0;
`ifdef FMAC_SCHED_CLAMP_CNT_EN
            e_cl = m_clamps;
`else
            e_cl = 0;
`endif
            chk("gnt", int'(gnt), e_gnt);
            chk("op_ready", int'(op_ready), e_rdy);
            chk("res_valid", int'(res_valid), (m_ph == 2) ? 1 : 0);
            chk("busy", int'(busy), (m_ph != 0) ? 1 : 0);
            if (m_ph == 2) begin
                chk("res_data", int'(res_data), m_acc);
                chk("res_id", int'(res_id), m_id);
                chk("res_clamps", int'(res_clamps), e_cl);
            end
            if (rst_n && res_valid && res_ready) begin
                d_data.push_back(int'(res_data));
                d_id.push_back(int'(res_id));
                d_cl.push_back(int'(res_clamps));
            end
        end
    end

    // ---------------- operand feeder ----------------
    initial begin
        bit hs0, hs1;
        op_valid = '0; op_x = '0; op_y = '0;
        forever begin
            @(negedge clk);
            hs0 = op_valid[0] && op_ready[0];
            hs1 = op_valid[1] && op_ready[1];
            @(posedge clk);
            #1;
            if (hs0 && pq0.size() > 0) void'(pq0.pop_front());
            if (hs1 && pq1.size() > 0) begin
                void'(pq1.pop_front());
                hs_cnt1++;
            end
            if (pq0.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
                op_valid[0] = 1'b1; op_x[7:0] = pq0[0][15:8]; op_y[7:0] = pq0[0][7:0];
            end else begin
                op_valid[0] = 1'b0; op_x[7:0] = 8'($urandom); op_y[7:0] = 8'($urandom);
            end
            if (pq1.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
                op_valid[1] = 1'b1; op_x[15:8] = pq1[0][15:8]; op_y[15:8] = pq1[0][7:0];
            end else begin
                op_valid[1] = 1'b0; op_x[15:8] = 8'($urandom); op_y[15:8] = 8'($urandom);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_gnt(input int i);
        int t;
        t = 0;
        while (!gnt[i] && t < 100) begin
            @(negedge clk); #1; t++;
        end
        if (!gnt[i]) begin
            checks++; errors++;
            $display("FAIL gnt_timeout: requester %0d got no grant, gnt=%0d", i, gnt);
        end
    endtask

    task automatic wait_res(input int target);
        int t;
        t = 0;
        while (d_data.size() < target && t < 400) begin
            @(negedge clk); #1; t++;
        end
        if (d_data.size() < target) begin
            checks++; errors++;
            $display("FAIL result_timeout: got %0d results required %0d", d_data.size(), target);
        end
    endtask

    task automatic run_job(input int i, input int len, input int thr);
        @(posedge clk); #1;
        job_len[i*8 +: 8]   = 8'(len);
        job_thr[i*16 +: 16] = 16'(thr);
        req[i] = 1'b1;
        wait_gnt(i);
        req[i] = 1'b0;
        wait_res(d_data.size() + 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_res(input string name, input int idx, input int data, input int id, input int cl);
        chk({name, "_data"},  (idx < d_data.size()) ? d_data[idx] : -1, data);
        chk({name, "_id"},    (idx < d_id.size())   ? d_id[idx]   : -1, id);
        chk({name, "_clamps"},(idx < d_cl.size())   ? d_cl[idx]   : -1, cl);
        chk({name, "_model"}, (idx < m_data.size()) ? m_data[idx] : -1, data);
        chk({name, "_model_id"}, (idx < m_idl.size()) ? m_idl[idx] : -1, id);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_gnt"}, int'(gnt), 0);
        chk({name, "_op_ready"}, int'(op_ready), 0);
        chk({name, "_res_valid"}, int'(res_valid), 0);
        chk({name, "_res_data"}, int'(res_data), 0);
        chk({name, "_res_id"}, int'(res_id), 0);
        chk({name, "_res_clamps"}, int'(res_clamps), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    function automatic logic [15:0] rand_pair();
        logic [7:0] x, y;
        x = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        y = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        return {x, y};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n0, t, base;
        rst_n = 1'b1; req = '0; job_len = '0; job_thr = '0; res_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic job: 2*3 + 4*5 + 1*1 = 27.
        res_ready = 1'b1;
        n0 = d_data.size();
        pq0.push_back({8'd2, 8'd3}); pq0.push_back({8'd4, 8'd5}); pq0.push_back({8'd1, 8'd1});
        run_job(0, 3, 0);
        chk_res("basic", n0, 27, 0, 0);

        // Threshold clamp: 25 < 100 -> 0, then 120.
        n0 = d_data.size();
        pq0.push_back({8'd5, 8'd5}); pq0.push_back({8'd10, 8'd12});
        run_job(0, 2, 100);
        chk_res("thresh", n0, 120, 0, CL1);

        // Overflow clamp: 65025, then 130050 overflows -> 0.
        n0 = d_data.size();
        pq0.push_back({8'd255, 8'd255}); pq0.push_back({8'd255, 8'd255});
        run_job(0, 2, 0);
        chk_res("ovf", n0, 0, 0, CL1);

        // Round robin from reset with both requesting.
        do_reset();
        @(posedge clk); #1;
        pq0.push_back({8'd1, 8'd2}); pq0.push_back({8'd3, 8'd4});
        pq1.push_back({8'd5, 8'd6}); pq1.push_back({8'd7, 8'd8});
        job_len = {8'd1, 8'd1}; job_thr = '0;
        n0 = d_data.size();
        req = 2'b11;
        wait_res(n0 + 4);
        req = '0;
        @(posedge clk); #1;
        chk_res("rr0", n0,     2,  0, 0);
        chk_res("rr1", n0 + 1, 30, 1, 0);
        chk_res("rr2", n0 + 2, 12, 0, 0);
        chk_res("rr3", n0 + 3, 56, 1, 0);

        // len=0 on requester 1 with result backpressure.
        @(posedge clk); #1;
        res_ready = 1'b0;
        n0 = d_data.size();
        job_len[15:8] = 8'd0;
        req[1] = 1'b1;
        wait_gnt(1);
        req[1] = 1'b0;
        pq0.push_back({8'd7, 8'd8});
        job_len[7:0] = 8'd1;
        req[0] = 1'b1;
        t = 0;
        while (!res_valid && t < 20) begin @(negedge clk); #1; t++; end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("bp_res_valid", int'(res_valid), 1);
            chk("bp_res_data", int'(res_data), 0);
            chk("bp_res_id", int'(res_id), 1);
            chk("bp_gnt", int'(gnt), 2);
            chk("bp_busy", int'(busy), 1);
            chk("bp_op_ready", int'(op_ready), 0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        wait_gnt(0);
        req[0] = 1'b0;
        wait_res(n0 + 2);
        @(posedge clk); #1;
        chk_res("len0", n0, 0, 1, 0);
        chk_res("after_bp", n0 + 1, 56, 0, 0);

        // Reset in the middle of a 4-element job.
        pq1.push_back({8'd1, 8'd1}); pq1.push_back({8'd2, 8'd2});
        pq1.push_back({8'd3, 8'd3}); pq1.push_back({8'd4, 8'd4});
        job_len[15:8] = 8'd4;
        base = hs_cnt1;
        req[1] = 1'b1;
        wait_gnt(1);
        req[1] = 1'b0;
        t = 0;
        while (hs_cnt1 - base < 2 && t < 100) begin @(posedge clk); #3; t++; end
        rst_n = 1'b0;
        #1 check_zero("midrun");
        pq0.delete(); pq1.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        pq0.push_back({8'd3, 8'd4}); pq1.push_back({8'd5, 8'd6});
        job_len = {8'd1, 8'd1};
        n0 = d_data.size();
        req = 2'b11;
        t = 0;
        while (gnt == '0 && t < 20) begin @(negedge clk); #1; t++; end
        chk("post_reset_gnt", int'(gnt), 1);
        wait_res(n0 + 2);
        req = '0;
        @(posedge clk); #1;
        chk_res("post_reset0", n0, 12, 0, 0);
        chk_res("post_reset1", n0 + 1, 30, 1, 0);

        // Randomized traffic, checked every cycle by the model.
        gap_mode = 1;
        n0 = d_data.size();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            req = 2'($urandom_range(0, 3));
            for (int i = 0; i < NREQ; i++) begin
                int r;
                job_len[i*8 +: 8] = 8'($urandom_range(0, 5));
                r = $urandom_range(0, 3);
                job_thr[i*16 +: 16] = (r == 0) ? 16'd0 :
                                      (r == 1) ? 16'($urandom_range(0, 2000)) :
                                      (r == 2) ? 16'($urandom) : 16'($urandom_range(0, 60));
            end
            res_ready = ($urandom_range(0, 2) != 0);
            while (pq0.size() < 8) pq0.push_back(rand_pair());
            while (pq1.size() < 8) pq1.push_back(rand_pair());
        end
        @(posedge clk); #1;
        req = '0; res_ready = 1'b1;
        t = 0;
        while (busy && t < 300) begin @(negedge clk); #1; t++; end
        chk("drain_busy", int'(busy), 0);
        chk("random_jobs_seen", (d_data.size() - n0 > 20) ? 1 : 0, 1);
        @(posedge clk); #1;
        chk("log_count", d_data.size(), m_data.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
